cache_2wsa: RTL and testbench

Two-way set-associative, write-back, write-allocate data cache between an 8-bit CPU port and a byte-wide main-memory port, both with 16-bit addresses. CPU hits complete in the request cycle. Misses stall the CPU while the cache writes back a dirty victim line (if any) and fills a 4-byte line from memory under a ready_mem handshake.

---
 rtl/cache_2wsa.sv | 158 +++++++++++++++
 tb/tb_cache_2wsa.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_2wsa.sv
// Two-way set-associative write-back, write-allocate data cache: 64 sets, 4-byte lines,
// 8-bit CPU port and byte-wide memory port with a ready_mem handshake.
module cache_2wsa (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] addr_cpu,
    input  logic        rd_cpu,
    input  logic        wr_cpu,
    inout  wire  [7:0]  data_cpu,
    output logic        stall_cpu,
    output logic [15:0] addr_mem,
    output logic        rd_mem,
    output logic        wr_mem,
    input  logic        ready_mem,
    inout  wire  [7:0]  data_mem
);
    typedef enum logic [1:0] {StCompare, StWriteback, StAllocate, StFill} state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_data  [2][64][4];
    logic [7:0]  r_tag   [2][64];
    logic [63:0] r_valid [2];
    logic [63:0] r_dirty [2];
    logic [63:0] r_lru;

    logic [13:0] r_miss_line;
    logic        r_way;
    logic [1:0]  r_k;
    logic        r_seen_low;

    logic [7:0]  w_tag;
    logic [5:0]  w_idx;
    logic [1:0]  w_off;
    logic [5:0]  w_m_idx;
    logic        w_hit0;
    logic        w_hit1;
    logic        w_hit;
    logic        w_hit_way;
    logic        w_victim;
    logic        w_victim_dirty;
    logic        w_rd_hit;
    logic        w_wr_hit;
    logic        w_miss;
    logic        w_stall;
    logic        w_fill_done;

    assign w_tag     = addr_cpu[15:8];
    assign w_idx     = addr_cpu[7:2];
    assign w_off     = addr_cpu[1:0];
    assign w_m_idx   = r_miss_line[5:0];
    assign w_hit0    = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1    = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit     = w_hit0 || w_hit1;
    assign w_hit_way = w_hit1;

    // First invalid way wins, way0 before way1; otherwise the LRU way.
    assign w_victim = !r_valid[0][w_idx] ? 1'b0 :
                      !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_victim_dirty = r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx];
    assign w_fill_done    = (r_state == StFill) && (r_k == 2'd3);

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_rd_hit    = 1'b0;
        w_wr_hit    = 1'b0;
        w_miss      = 1'b0;
        rd_mem      = 1'b0;
        wr_mem      = 1'b0;
        addr_mem    = 16'h0000;
        unique case (r_state)
            StCompare: begin
                if (rd_cpu || wr_cpu) begin
                    if (w_hit) begin
                        w_wr_hit = wr_cpu;
                        w_rd_hit = !wr_cpu;
                    end else begin
                        w_miss      = 1'b1;
                        w_stall     = 1'b1;
                        w_state_nxt = w_victim_dirty ? StWriteback : StAllocate;
                    end
                end
            end
            StWriteback: begin
                w_stall  = 1'b1;
                wr_mem   = 1'b1;
                addr_mem = {r_tag[r_way][w_m_idx], w_m_idx, r_k};
                if (r_seen_low && ready_mem) w_state_nxt = StAllocate;
            end
            StAllocate: begin
                w_stall  = 1'b1;
                rd_mem   = 1'b1;
                addr_mem = {r_miss_line, 2'b00};
                if (r_seen_low && ready_mem) w_state_nxt = StFill;
            end
            StFill: begin
                w_stall  = 1'b1;
                addr_mem = {r_miss_line, r_k};
                if (r_k == 2'd3) w_state_nxt = StCompare;
            end
        endcase
    end

    // A held CPU request would otherwise re-raise stall while reset is asserted.
    assign stall_cpu = w_stall && reset_n;
    assign data_cpu  = w_rd_hit ? r_data[w_hit_way][w_idx][w_off] : 8'hzz;
    assign data_mem  = (r_state == StWriteback) ? r_data[r_way][w_m_idx][r_k] : 8'hzz;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StCompare;
            r_valid[0]  <= '0;
            r_valid[1]  <= '0;
            r_dirty[0]  <= '0;
            r_dirty[1]  <= '0;
            r_lru       <= '0;
            r_miss_line <= '0;
            r_way       <= 1'b0;
            r_k         <= 2'd0;
            r_seen_low  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != w_state_nxt) begin
                r_k        <= 2'd0;
                r_seen_low <= 1'b0;
            end else if (r_state == StWriteback) begin
                if (r_k != 2'd3) r_k <= r_k + 2'd1;
                if (!ready_mem) r_seen_low <= 1'b1;
            end else if (r_state == StAllocate) begin
                if (!ready_mem) r_seen_low <= 1'b1;
            end else if (r_state == StFill) begin
                r_k <= r_k + 2'd1;
            end
            if (w_miss) begin
                r_miss_line <= addr_cpu[15:2];
                r_way       <= w_victim;
            end
            if (w_rd_hit || w_wr_hit) r_lru[w_idx] <= ~w_hit_way;
            if (w_wr_hit) r_dirty[w_hit_way][w_idx] <= 1'b1;
            if ((r_state == StWriteback) && (w_state_nxt == StAllocate)) begin
                r_dirty[r_way][w_m_idx] <= 1'b0;
            end
            if (w_fill_done) begin
                r_valid[r_way][w_m_idx] <= 1'b1;
                r_dirty[r_way][w_m_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_hit) r_data[w_hit_way][w_idx][w_off] <= data_cpu;
        if (r_state == StFill) r_data[r_way][w_m_idx][r_k] <= data_mem;
        if (w_fill_done) r_tag[r_way][w_m_idx] <= r_miss_line[13:6];
    end

endmodule

// File: tb/tb_cache_2wsa.sv
// Directed bench for cache_2wsa: a byte memory model answers line fills and
// write-backs; expected data, fill addresses and write-back bytes go through queues.
module tb_cache_2wsa;
    logic        clock;
    logic        reset_n;
    logic [15:0] addr_cpu;
    logic        rd_cpu;
    logic        wr_cpu;
    wire  [7:0]  data_cpu;
    logic        stall_cpu;
    logic [15:0] addr_mem;
    logic        rd_mem;
    logic        wr_mem;
    logic        ready_mem;
    wire  [7:0]  data_mem;

    logic        cpu_oe;
    logic [7:0]  cpu_drv;
    logic        mem_oe;
    logic [7:0]  mem_drv;
    logic [7:0]  mem [65536];

    int          checks;
    int          failures;
    int          overlap;
    string       step;

    logic [7:0]  exp_data_q   [$];
    logic [15:0] exp_rdaddr_q [$];
    logic [23:0] exp_wb_q     [$];
    logic [15:0] rd_addr_q    [$];
    logic [23:0] wb_q         [$];

    assign data_cpu = cpu_oe ? cpu_drv : 8'hzz;
    assign data_mem = mem_oe ? mem_drv : 8'hzz;

    cache_2wsa dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .addr_cpu  (addr_cpu),
        .rd_cpu    (rd_cpu),
        .wr_cpu    (wr_cpu),
        .data_cpu  (data_cpu),
        .stall_cpu (stall_cpu),
        .addr_mem  (addr_mem),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .ready_mem (ready_mem),
        .data_mem  (data_mem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rd_mem && wr_mem) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
        end
    endtask

    // Memory: ready_mem low for 4 cycles per request, then four fill bytes if a read.
    initial begin : mem_model
        logic        is_rd;
        logic [15:0] base;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0090] = 8'h11; mem[16'h0091] = 8'h22; mem[16'h0092] = 8'h33; mem[16'h0093] = 8'h44;
        mem[16'hC088] = 8'h11; mem[16'hC089] = 8'h22; mem[16'hC08A] = 8'h33; mem[16'hC08B] = 8'h44;
        mem[16'hC090] = 8'h51; mem[16'hC091] = 8'h52; mem[16'hC092] = 8'h53; mem[16'hC093] = 8'h54;
        mem[16'h4090] = 8'hAA; mem[16'h4091] = 8'hBB; mem[16'h4092] = 8'hCC; mem[16'h4093] = 8'hDD;
        mem[16'h5000] = 8'h61; mem[16'h5001] = 8'h62; mem[16'h5002] = 8'h63; mem[16'h5003] = 8'h64;
        ready_mem = 1'b1;
        mem_oe    = 1'b0;
        mem_drv   = 8'h00;
        overlap   = 0;
        forever begin
            @(negedge clock);
            if (rd_mem === 1'b1 || wr_mem === 1'b1) begin
                is_rd     = rd_mem;
                base      = addr_mem;
                ready_mem = 1'b0;
                if (is_rd) rd_addr_q.push_back(base);
                for (int i = 0; i < 4; i++) begin
                    if (!is_rd) begin
                        wb_q.push_back({addr_mem, data_mem});
                        mem[addr_mem] = data_mem;
                    end
                    @(negedge clock);
                end
                ready_mem = 1'b1;
                if (is_rd) begin
                    @(negedge clock);
                    for (int b = 0; b < 4; b++) begin
                        mem_drv = mem[base + 16'(b)];
                        mem_oe  = 1'b1;
                        @(negedge clock);
                    end
                    mem_oe = 1'b0;
                end
            end
        end
    end

    task automatic drain_mem();
        logic [15:0] oa;
        logic [23:0] ow;
        while (exp_rdaddr_q.size() > 0) begin
            oa = 16'hFFFF;
            if (rd_addr_q.size() > 0) oa = rd_addr_q.pop_front();
            check("fill_addr", 32'(oa), 32'(exp_rdaddr_q.pop_front()));
        end
        while (exp_wb_q.size() > 0) begin
            ow = 24'hFFFFFF;
            if (wb_q.size() > 0) ow = wb_q.pop_front();
            check("wb_addr_data", 32'(ow), 32'(exp_wb_q.pop_front()));
        end
        check("extra_fills", 32'(rd_addr_q.size()), 32'd0);
        check("extra_wbs", 32'(wb_q.size()), 32'd0);
    endtask

    task automatic wait_stall_low(output int n);
        n = 0;
        while (stall_cpu !== 1'b0 && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
    endtask

    task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp_d, input int exp_stall);
        int n;
        exp_data_q.push_back(exp_d);
        @(negedge clock);
        addr_cpu = a;
        rd_cpu   = 1'b1;
        wr_cpu   = 1'b0;
        #1;
        wait_stall_low(n);
        check("stall_cycles", 32'(n), 32'(exp_stall));
        check("data_cpu", 32'(data_cpu), 32'(exp_data_q.pop_front()));
        @(negedge clock);
        rd_cpu = 1'b0;
        drain_mem();
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int exp_stall);
        int n;
        @(negedge clock);
        addr_cpu = a;
        cpu_drv  = d;
        cpu_oe   = 1'b1;
        wr_cpu   = 1'b1;
        rd_cpu   = 1'b0;
        #1;
        wait_stall_low(n);
        check("wr_stall_cycles", 32'(n), 32'(exp_stall));
        @(negedge clock);
        wr_cpu = 1'b0;
        cpu_oe = 1'b0;
        drain_mem();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        rd_cpu   = 1'b0;
        wr_cpu   = 1'b0;
        addr_cpu = 16'h0000;
        cpu_oe   = 1'b0;
        cpu_drv  = 8'h00;

        step = "reset";
        #1;
        check("stall_cpu", 32'(stall_cpu), 32'd0);
        check("rd_mem", 32'(rd_mem), 32'd0);
        check("wr_mem", 32'(wr_mem), 32'd0);
        check("addr_mem", 32'(addr_mem), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        step = "cold_read_0093";
        exp_rdaddr_q.push_back(16'h0090);
        cpu_read(16'h0093, 8'h44, 10);

        step = "write_hit_0093";
        cpu_write(16'h0093, 8'h23, 0);
        step = "read_hit_0093";
        cpu_read(16'h0093, 8'h23, 0);

        step = "miss_C08B";
        exp_rdaddr_q.push_back(16'hC088);
        cpu_read(16'hC08B, 8'h44, 10);

        step = "miss_C093_way1";
        exp_rdaddr_q.push_back(16'hC090);
        cpu_read(16'hC093, 8'h54, 10);

        step = "dirty_evict_4093";
        exp_wb_q.push_back({16'h0090, 8'h11});
        exp_wb_q.push_back({16'h0091, 8'h22});
        exp_wb_q.push_back({16'h0092, 8'h33});
        exp_wb_q.push_back({16'h0093, 8'h23});
        exp_rdaddr_q.push_back(16'h4090);
        cpu_read(16'h4093, 8'hDD, 15);

        step = "hit_C093";
        cpu_read(16'hC093, 8'h54, 0);

        step = "clean_evict_0093";
        exp_rdaddr_q.push_back(16'h0090);
        cpu_read(16'h0093, 8'h23, 10);

        step = "reset_mid_fill";
        exp_rdaddr_q.push_back(16'h5000);
        @(negedge clock);
        addr_cpu = 16'h5000;
        rd_cpu   = 1'b1;
        n = 0;
        while (rd_mem !== 1'b1 && n < 50) begin @(negedge clock); #1; n++; end
        check("rd_mem_rise_bound", 32'(n < 50), 32'd1);
        n = 0;
        while (rd_mem !== 1'b0 && n < 50) begin @(negedge clock); #1; n++; end
        check("rd_mem_fall_bound", 32'(n < 50), 32'd1);
        @(negedge clock);
        #1;
        check("stall_in_fill", 32'(stall_cpu), 32'd1);
        reset_n = 1'b0;
        #1;
        check("stall_on_reset", 32'(stall_cpu), 32'd0);
        check("rd_mem_on_reset", 32'(rd_mem), 32'd0);
        check("wr_mem_on_reset", 32'(wr_mem), 32'd0);
        rd_cpu = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (8) @(negedge clock);
        drain_mem();

        step = "reread_5000";
        exp_rdaddr_q.push_back(16'h5000);
        cpu_read(16'h5000, 8'h61, 10);

        step = "end";
        check("rd_wr_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
